set_assoc_cache_sim: RTL and testbench

Parametrised set-associative cache simulator core. It accepts one memory-trace address per handshake and classifies it as hit or miss against an internal tag store with LRU replacement. It models fill latency for misses and keeps saturating hit, miss and eviction counters. It replaces the fixed direct-mapped simulator core that sits between the trace source and the statistics readout, and adds configurable associativity, block size and set count, a valid/ready input and eviction statistics.

---
 rtl/set_assoc_cache_sim.sv | 178 +++++++++++++++++
 tb/tb_set_assoc_cache_sim.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/set_assoc_cache_sim.sv
// Set-associative cache simulator core: classifies trace addresses as hit or miss with LRU
// replacement, models lookup and fill latency, and keeps saturating hit/miss/evict counters.
module set_assoc_cache_sim #(
  parameter int ADDR_W      = 16,
  parameter int OFFSET_BITS = 2,
  parameter int INDEX_BITS  = 2,
  parameter int WAYS        = 2,
  parameter int CNT_W       = 16,
  parameter int LOOKUP_CYC  = 3,
  parameter int MEM_LAT     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              trace_valid,
  input  logic [ADDR_W-1:0] trace_addr,
  output logic              trace_ready,
  input  logic              stat_clear,
  output logic              done_valid,
  output logic              done_hit,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  evict_count,
  output logic [1:0]        dbg_state
);
  localparam int TAG_W    = ADDR_W - OFFSET_BITS - INDEX_BITS;
  localparam int SETS     = 1 << INDEX_BITS;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int AGE_W    = WAY_W;
  localparam int FILL_CYC = MEM_LAT + (1 << OFFSET_BITS);
  localparam int MAX_CYC  = (LOOKUP_CYC > FILL_CYC) ? LOOKUP_CYC : FILL_CYC;
  localparam int CYC_W    = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOOKUP = 2'd1,
    S_FILL   = 2'd2,
    S_UPDATE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [CYC_W-1:0]   r_cyc;
  logic [TAG_W-1:0]   r_tag_q;
  logic [INDEX_BITS-1:0] r_idx;
  logic               r_hit, r_victim_valid;
  logic [WAY_W-1:0]   r_way;
  logic               r_done_valid, r_done_hit;
  logic [CNT_W-1:0]   r_hit_cnt, r_miss_cnt, r_evict_cnt;
  logic               r_valid [SETS][WAYS];
  logic [TAG_W-1:0]   r_tag   [SETS][WAYS];
  logic [AGE_W-1:0]   r_age   [SETS][WAYS];

  logic               w_accept, w_lookup_last, w_fill_last, w_hit, w_victim_valid;
  logic [WAY_W-1:0]   w_hit_way, w_victim;
  logic               w_unused_offset;

  // Handshake: an address transfers on the rising edge where trace_valid && trace_ready;
  // trace_ready is high only in IDLE outside reset, and trace_addr is sampled only then.
  assign trace_ready     = (r_state == S_IDLE) && !rst;
  assign w_accept        = trace_valid && trace_ready;
  assign w_lookup_last   = (r_cyc == CYC_W'(LOOKUP_CYC - 1));
  assign w_fill_last     = (r_cyc == CYC_W'(FILL_CYC - 1));
  assign w_unused_offset = ^trace_addr[OFFSET_BITS-1:0];
  assign done_valid      = r_done_valid;
  assign done_hit        = r_done_hit;
  assign hit_count       = r_hit_cnt;
  assign miss_count      = r_miss_cnt;
  assign evict_count     = r_evict_cnt;
  assign dbg_state       = r_state;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[r_idx][w] && (r_tag[r_idx][w] == r_tag_q)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Lowest invalid way first; with a full set the oldest line (age WAYS-1) is replaced.
  always_comb begin
    w_victim       = '0;
    w_victim_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[r_idx][w]) begin
        w_victim       = WAY_W'(w);
        w_victim_valid = 1'b0;
      end
    end
    if (w_victim_valid) begin
      for (int w = 0; w < WAYS; w++) begin
        if (r_age[r_idx][w] == AGE_W'(WAYS - 1)) w_victim = WAY_W'(w);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_state_nxt = S_LOOKUP;
      S_LOOKUP: if (w_lookup_last) w_state_nxt = w_hit ? S_UPDATE : S_FILL;
      S_FILL:   if (w_fill_last) w_state_nxt = S_UPDATE;
      S_UPDATE: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cyc          <= '0;
      r_tag_q        <= '0;
      r_idx          <= '0;
      r_hit          <= 1'b0;
      r_way          <= '0;
      r_victim_valid <= 1'b0;
      r_done_valid   <= 1'b0;
      r_done_hit     <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_done_valid <= 1'b0;
      r_cyc        <= (w_state_nxt != r_state || r_state == S_IDLE) ? '0 : r_cyc + 1'b1;
      if (w_accept) begin
        r_tag_q <= trace_addr[ADDR_W-1:OFFSET_BITS+INDEX_BITS];
        r_idx   <= trace_addr[OFFSET_BITS+INDEX_BITS-1:OFFSET_BITS];
      end
      if (r_state == S_LOOKUP && w_lookup_last) begin
        r_hit          <= w_hit;
        r_way          <= w_hit ? w_hit_way : w_victim;
        r_victim_valid <= !w_hit && w_victim_valid;
      end
      if (r_state == S_UPDATE) begin
        r_done_valid <= 1'b1;
        r_done_hit   <= r_hit;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          r_valid[s][w] <= 1'b0;
          r_tag[s][w]   <= '0;
          r_age[s][w]   <= AGE_W'(w);
        end
      end
    end else if (r_state == S_UPDATE) begin
      r_valid[r_idx][r_way] <= 1'b1;
      r_tag[r_idx][r_way]   <= r_tag_q;
      for (int w = 0; w < WAYS; w++) begin
        if (WAY_W'(w) == r_way) r_age[r_idx][w] <= '0;
        else if (r_age[r_idx][w] < r_age[r_idx][r_way]) r_age[r_idx][w] <= r_age[r_idx][w] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || stat_clear) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else if (r_state == S_UPDATE) begin
      if (r_hit) begin
        r_hit_cnt <= sat_inc(r_hit_cnt);
      end else begin
        r_miss_cnt <= sat_inc(r_miss_cnt);
        if (r_victim_valid) r_evict_cnt <= sat_inc(r_evict_cnt);
      end
    end
  end

endmodule

// File: tb/tb_set_assoc_cache_sim.sv
// Directed bench for set_assoc_cache_sim: default, direct-mapped and 4-bit-counter instances
// driven through one access task, with hand-computed hit/miss sequences and counter values.
module tb_set_assoc_cache_sim;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tv [3];
  logic [15:0] ta [3];
  logic        sc [3];
  logic        tr [3];
  logic        dv [3];
  logic        dh [3];
  logic [15:0] hc [3];
  logic [15:0] mc [3];
  logic [15:0] ec [3];
  logic [1:0]  dbg [3];
  logic [3:0]  sat_hc, sat_mc, sat_ec;
  int          n_total = 0;
  int          n_bad   = 0;
  logic [0:0]  exp_q [$];

  logic [15:0] dm_addr [12] = '{16'd0, 16'd9, 16'd8, 16'd1, 16'd4, 16'd5,
                                16'd10, 16'd4, 16'd12, 16'd16, 16'd13, 16'd18};
  logic        dm_exp  [12] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                                1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [15:0] sa_addr [6]  = '{16'd0, 16'd16, 16'd0, 16'd32, 16'd16, 16'd32};
  logic        sa_exp  [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  set_assoc_cache_sim u_dut (
    .clk(clk), .rst(rst), .trace_valid(tv[0]), .trace_addr(ta[0]), .trace_ready(tr[0]),
    .stat_clear(sc[0]), .done_valid(dv[0]), .done_hit(dh[0]), .hit_count(hc[0]),
    .miss_count(mc[0]), .evict_count(ec[0]), .dbg_state(dbg[0])
  );

  set_assoc_cache_sim #(.WAYS(1)) u_dm (
    .clk(clk), .rst(rst), .trace_valid(tv[1]), .trace_addr(ta[1]), .trace_ready(tr[1]),
    .stat_clear(sc[1]), .done_valid(dv[1]), .done_hit(dh[1]), .hit_count(hc[1]),
    .miss_count(mc[1]), .evict_count(ec[1]), .dbg_state(dbg[1])
  );

  set_assoc_cache_sim #(.CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .trace_valid(tv[2]), .trace_addr(ta[2]), .trace_ready(tr[2]),
    .stat_clear(sc[2]), .done_valid(dv[2]), .done_hit(dh[2]), .hit_count(sat_hc),
    .miss_count(sat_mc), .evict_count(sat_ec), .dbg_state(dbg[2])
  );

  assign hc[2] = {12'd0, sat_hc};
  assign mc[2] = {12'd0, sat_mc};
  assign ec[2] = {12'd0, sat_ec};

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_counts(input int s, input string tag, input int h, input int m, input int e);
    check({tag, "_hit_count"}, 32'(hc[s]), 32'(h));
    check({tag, "_miss_count"}, 32'(mc[s]), 32'(m));
    check({tag, "_evict_count"}, 32'(ec[s]), 32'(e));
  endtask

  // driver: called #1 after a rising edge; clr_at raises stat_clear for edge E0+clr_at
  task automatic access(input int s, input logic [15:0] a, input int clr_at,
                        output logic hit, output int lat);
    logic busy_rdy, done_rdy;
    int   w;
    w = 0;
    while (!tr[s] && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    tv[s] = 1'b1;
    ta[s] = a;
    @(posedge clk); #1;
    tv[s] = 1'b0;
    ta[s] = 16'hffff;
    lat = 0; hit = 1'b0; busy_rdy = 1'b0; done_rdy = 1'b0;
    for (int c = 1; c <= 60 && lat == 0; c++) begin
      sc[s] = (c == clr_at);
      @(posedge clk); #1;
      sc[s] = 1'b0;
      if (dv[s]) begin
        lat      = c;
        hit      = dh[s];
        done_rdy = tr[s];
      end else if (tr[s]) begin
        busy_rdy = 1'b1;
      end
    end
    check("done_seen", 32'(lat != 0), 32'd1);
    check("ready_low_in_flight", 32'(busy_rdy), 32'd0);
    check("ready_in_done_cycle", 32'(done_rdy), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic hit;
    logic e;
    int   lat;
    int   dv_seen;
    for (int i = 0; i < 3; i++) begin
      tv[i] = 1'b0; ta[i] = '0; sc[i] = 1'b0;
    end

    // reset state
    #1 rst = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check_counts(0, "reset", 0, 0, 0);
    check("reset_done_valid", 32'(dv[0]), 32'd0);
    check("reset_done_hit", 32'(dh[0]), 32'd0);
    check("reset_ready", 32'(tr[0]), 32'd0);
    check("reset_state", 32'(dbg[0]), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("ready_after_release", 32'(tr[0]), 32'd1);

    // latency: miss then back-to-back hit
    access(0, 16'd0, 0, hit, lat);
    check("lat_miss", 32'(lat), 32'd11);
    check("lat_miss_hit", 32'(hit), 32'd0);
    access(0, 16'd1, 0, hit, lat);
    check("lat_hit", 32'(lat), 32'd4);
    check("lat_hit_hit", 32'(hit), 32'd1);
    @(posedge clk); #1;
    check("done_single_pulse", 32'(dv[0]), 32'd0);
    check_counts(0, "latency", 1, 1, 0);

    // stat_clear coincident with a hit's completion, then one more hit
    access(0, 16'd0, 4, hit, lat);
    check("clr_hit", 32'(hit), 32'd1);
    check_counts(0, "clr", 0, 0, 0);
    access(0, 16'd2, 0, hit, lat);
    check("after_clr_hit", 32'(hit), 32'd1);
    check_counts(0, "after_clr", 1, 0, 0);

    // two-way LRU trace, all in set 0
    do_reset();
    for (int i = 0; i < 6; i++) exp_q.push_back(sa_exp[i]);
    for (int i = 0; i < 6; i++) begin
      access(0, sa_addr[i], 0, hit, lat);
      e = exp_q.pop_front();
      check($sformatf("lru_hit[%0d]", i), 32'(hit), 32'(e));
      check($sformatf("lru_lat[%0d]", i), 32'(lat), e ? 32'd4 : 32'd11);
    end
    check_counts(0, "lru", 2, 4, 2);

    // reset in the middle of a fill
    tv[0] = 1'b1; ta[0] = 16'd0;
    @(posedge clk); #1;
    tv[0] = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    check("midfill_state", 32'(dbg[0]), 32'd2);
    rst = 1'b1;
    #1;
    check_counts(0, "async_rst", 0, 0, 0);
    check("async_rst_ready", 32'(tr[0]), 32'd0);
    dv_seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (dv[0]) dv_seen++;
    end
    check("no_done_in_reset", 32'(dv_seen), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    access(0, 16'd0, 0, hit, lat);
    check("after_rst_hit", 32'(hit), 32'd0);
    check("after_rst_lat", 32'(lat), 32'd11);
    check_counts(0, "after_rst", 0, 1, 0);

    // direct-mapped trace
    for (int i = 0; i < 12; i++) exp_q.push_back(dm_exp[i]);
    for (int i = 0; i < 12; i++) begin
      access(1, dm_addr[i], 0, hit, lat);
      e = exp_q.pop_front();
      check($sformatf("dm_hit[%0d]", i), 32'(hit), 32'(e));
      check($sformatf("dm_lat[%0d]", i), 32'(lat), e ? 32'd4 : 32'd11);
    end
    check_counts(1, "dm", 7, 5, 1);

    // 4-bit counters saturate
    access(2, 16'd0, 0, hit, lat);
    check("sat_first_miss", 32'(hit), 32'd0);
    for (int i = 0; i < 20; i++) begin
      access(2, 16'd3, 0, hit, lat);
      check($sformatf("sat_hit[%0d]", i), 32'(hit), 32'd1);
      if (i == 14) check("sat_hit_count_15", 32'(hc[2]), 32'd15);
    end
    check_counts(2, "sat", 15, 1, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
